nop_core_param: RTL and testbench
=================================

// Module: nop_core_param
// PURPOSE
//  Parametrised multi-cycle successor to the 8-bit nopCPU core. Combines fetch/execute FSM, PC, register file, ALU and interrupt logic.
//  Generalises data width, address width and register count. Adds a req/ack data-memory handshake, zero flag, interrupt enable, RETI and HALT.
//  Sits between a combinational instruction ROM and a handshaked data memory.
// PARAMETERS
//  DATA_W   8      datapath/register width (>=8)
//  ADDR_W   8      instruction and data address width (>=4)
//  NREGS    4      register count, power of two, 2..16; reg fields use low $clog2(NREGS) bits
//  IRQ_VEC  'hF0   interrupt vector, truncated to ADDR_W
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-low reset
//  irq         in   1       level-sensitive interrupt request
//  imem_addr   out  ADDR_W  instruction address (=PC)
//  imem_data   in   16      instruction word, combinational from imem_addr
//  dmem_req    out  1       data access request
//  dmem_we     out  1       1=store 0=load, valid with req
//  dmem_addr   out  ADDR_W  data address, valid with req
//  dmem_wdata  out  DATA_W  store data, valid with req
//  dmem_rdata  in   DATA_W  load data, sampled on the ack cycle
//  dmem_ack    in   1       access complete
//  halted      out  1       core in HALT state
// BEHAVIOUR
//  Instruction format: [15:12] op, [11:8] rd, [7:4] rs, [7:0] imm8 (zero-extended/truncated to DATA_W/ADDR_W).
//  Ops (hex):
//   0 NOP; 1 LDI rd=imm; 2 ADD rd+=rs; 3 SUB rd-=rs; 4 AND; 5 OR; 6 XOR; 7 SHL rd=rs<<1
//   8 LD rd=M[rs]; 9 ST M[rs]=rd; A JMP imm; B JZ imm (if Z); C RETI; D EI; E DI; F HALT
//  Arithmetic: modulo 2^DATA_W, carry discarded. Z<=(result==0) on ops 2-7 only; LD does not touch Z.
//  Reset (async, reset=0): PC=0, all regs=0, Z=0, IE=0, EPC=0, state=FETCH.
//   Outputs: dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, halted=0.
//   Reset during a pending access drops req immediately; the access is abandoned.
//  FSM states: FETCH, EXEC, MEM, HALT.
//  FETCH:
//   If irq&&IE: EPC<=PC, PC<=IRQ_VEC, IE<=0, stay FETCH (1 cycle).
//   Else IR<=imem_data, PC<=PC+1 (wraps at 2^ADDR_W), go to EXEC.
//  EXEC:
//   ALU/LDI/NOP/EI/DI write back, then FETCH (2 cycles/instr).
//   JMP/taken JZ: PC<=imm. RETI: PC<=EPC, IE<=1. Both then FETCH.
//   LD/ST: drive req=1, addr=rs[ADDR_W-1:0], we, wdata=rd; go to MEM.
//   HALT: go to HALT.
//  MEM:
//   Hold req/addr/we/wdata stable until dmem_ack=1.
//   On the ack edge: LD writes rd<=dmem_rdata; req<=0 next cycle; go to FETCH. Ack with req=0 is ignored.
//  HALT: halted=1; leaves only on irq&&IE (treated as at FETCH) or reset.
//  IRQ is sampled only in FETCH/HALT; an interrupt taken is held off until IE is re-enabled.
//   No nesting: IE is cleared on entry.
//  Register write and read of same reg in one instruction (ADD r1,r1) uses the old value.
//  Illegal reg indices ≥NREGS alias via truncation.
// CONFIGURATION
//  NOPCPU_MUL_EN defined: op 7 = MUL, rd = (rd*rs)[DATA_W-1:0], Z updated, still 2 cycles.
//  NOPCPU_MUL_EN undefined: op 7 = SHL as above; no multiplier inferred.
// TESTING
//  1. Reset then LDI r1,5; LDI r2,3; ADD r1,r2 -> r1=8, Z=0, PC=3 after 6 cycles.
//  2. LDI r1,1; LDI r2,1; SUB r1,r2; JZ 0x20 -> Z=1, imem_addr=0x20 on next FETCH.
//  3. ST r1,[r2] with ack after 3 wait cycles -> req high 4 cycles, addr/wdata stable, then req=0.
//     LD r3,[r2] with rdata=0xA5 -> r3=0xA5.
//  4. EI; irq=1 during FETCH at PC=0x10 -> EPC=0x10, PC=IRQ_VEC, IE=0.
//     Handler RETI -> PC=0x10, IE=1.
//  5. HALT -> halted=1, PC frozen; irq with IE=0 ignored.
//     Assert reset mid-LD (req=1) -> req=0 asynchronously, PC=0, halted=0.
//  6. MUL_EN build: LDI r1,0x10; LDI r2,0x10; op7 r1,r2 -> r1=0x00, Z=1 (DATA_W=8).
//     Non-MUL build: r1=0x20.

Source files
------------

// File: rtl/nop_core_param.sv
// nop_core_param: parametrised multi-cycle nopCPU core (fetch/exec FSM, PC, register file, ALU, IRQ).
// Build option NOPCPU_MUL_EN: op 7 becomes rd = (rd*rs) low half instead of rd = rs << 1.
module nop_core_param #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned NREGS   = 4,
  parameter int unsigned IRQ_VEC = 'hF0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              irq,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              halted
);

  localparam int unsigned RIDX_W = $clog2(NREGS);
  localparam logic [ADDR_W-1:0] IRQ_PC = ADDR_W'(IRQ_VEC);

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_RETI = 4'hC;
  localparam logic [3:0] OP_EI   = 4'hD;
  localparam logic [3:0] OP_DI   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t              state_q, state_nx;
  logic [ADDR_W-1:0]   pc_q, pc_nx;
  logic [ADDR_W-1:0]   epc_q, epc_nx;
  logic                ie_q, ie_nx;
  logic                z_q, z_nx;
  logic [15:0]         ir_q, ir_nx;
  logic [DATA_W-1:0]   regs [NREGS];

  logic                req_nx, we_nx, halted_nx;
  logic [ADDR_W-1:0]   addr_nx;
  logic [DATA_W-1:0]   wdata_nx;

  logic                rf_we;
  logic [DATA_W-1:0]   rf_wdata;
  logic [DATA_W-1:0]   alu_res;

  logic [3:0]          op;
  logic [RIDX_W-1:0]   rd_idx, rs_idx;
  logic [DATA_W-1:0]   rd_val, rs_val, imm_d;
  logic [ADDR_W-1:0]   imm_a;
  logic                take_irq;
  logic                unused_ir;

  // Instruction field decode; out-of-range register fields alias by truncation
  assign op        = ir_q[15:12];
  assign rd_idx    = ir_q[8 +: RIDX_W];
  assign rs_idx    = ir_q[4 +: RIDX_W];
  assign imm_d     = DATA_W'(ir_q[7:0]);
  assign imm_a     = ADDR_W'(ir_q[7:0]);
  assign rd_val    = regs[rd_idx];
  assign rs_val    = regs[rs_idx];
  assign take_irq  = irq & ie_q;
  assign imem_addr = pc_q;
  assign unused_ir = ^ir_q;

  always_comb begin : alu
    alu_res = '0;
    case (op)
      OP_ADD: alu_res = rd_val + rs_val;
      OP_SUB: alu_res = rd_val - rs_val;
      OP_AND: alu_res = rd_val & rs_val;
      OP_OR:  alu_res = rd_val | rs_val;
      OP_XOR: alu_res = rd_val ^ rs_val;
`ifdef NOPCPU_MUL_EN
      OP_SHL: alu_res = rd_val * rs_val;
`else
      OP_SHL: alu_res = rs_val << 1;
`endif
      default: alu_res = '0;
    endcase
  end

  always_comb begin : next_state_logic
    state_nx = state_q;
    pc_nx    = pc_q;
    epc_nx   = epc_q;
    ie_nx    = ie_q;
    z_nx     = z_q;
    ir_nx    = ir_q;
    req_nx   = dmem_req;
    we_nx    = dmem_we;
    addr_nx  = dmem_addr;
    wdata_nx = dmem_wdata;
    rf_we    = 1'b0;
    rf_wdata = alu_res;

    case (state_q)
      S_FETCH: begin
        if (take_irq) begin
          epc_nx = pc_q;
          pc_nx  = IRQ_PC;
          ie_nx  = 1'b0;
        end else begin
          ir_nx    = imem_data;
          pc_nx    = pc_q + ADDR_W'(1);
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        state_nx = S_FETCH;
        case (op)
          OP_LDI: begin
            rf_we    = 1'b1;
            rf_wdata = imm_d;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL: begin
            rf_we = 1'b1;
            z_nx  = (alu_res == '0);
          end
          OP_LD, OP_ST: begin
            req_nx   = 1'b1;
            we_nx    = (op == OP_ST);
            addr_nx  = ADDR_W'(rs_val);
            wdata_nx = rd_val;
            state_nx = S_MEM;
          end
          OP_JMP: pc_nx = imm_a;
          OP_JZ: begin
            if (z_q) pc_nx = imm_a;
          end
          OP_RETI: begin
            pc_nx = epc_q;
            ie_nx = 1'b1;
          end
          OP_EI:   ie_nx = 1'b1;
          OP_DI:   ie_nx = 1'b0;
          OP_HALT: state_nx = S_HALT;
          default: state_nx = S_FETCH;
        endcase
      end
      // Request fields stay frozen until the ack edge
      S_MEM: begin
        if (dmem_ack) begin
          if (!dmem_we) begin
            rf_we    = 1'b1;
            rf_wdata = dmem_rdata;
          end
          req_nx   = 1'b0;
          state_nx = S_FETCH;
        end
      end
      S_HALT: begin
        if (take_irq) begin
          epc_nx   = pc_q;
          pc_nx    = IRQ_PC;
          ie_nx    = 1'b0;
          state_nx = S_FETCH;
        end
      end
      default: state_nx = S_FETCH;
    endcase
  end

  assign halted_nx = (state_nx == S_HALT);

  always_ff @(posedge clk or negedge reset) begin : state_reg
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin : datapath_reg
    if (!reset) begin
      pc_q       <= '0;
      epc_q      <= '0;
      ie_q       <= 1'b0;
      z_q        <= 1'b0;
      ir_q       <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      halted     <= 1'b0;
    end else begin
      pc_q       <= pc_nx;
      epc_q      <= epc_nx;
      ie_q       <= ie_nx;
      z_q        <= z_nx;
      ir_q       <= ir_nx;
      dmem_req   <= req_nx;
      dmem_we    <= we_nx;
      dmem_addr  <= addr_nx;
      dmem_wdata <= wdata_nx;
      halted     <= halted_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin : regfile
    if (!reset) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (rf_we) begin
      regs[rd_idx] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_nop_core_param.sv
// tb_nop_core_param: directed program checks plus randomized programs against an instruction-level model.
module tb_nop_core_param;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned NREGS   = 4;
  localparam int unsigned IRQ_VEC = 'hF0;
  localparam int DMOD = 256;
  localparam int AMOD = 256;

  logic              clk = 1'b0;
  logic              reset;
  logic              irq;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_data;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;
  logic              halted;

  logic [15:0] rom [256];
  assign imem_data = rom[imem_addr];

  nop_core_param #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS), .IRQ_VEC(IRQ_VEC)
  ) dut (
    .clk(clk), .reset(reset), .irq(irq),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .halted(halted)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Architectural model: one fetched-but-unexecuted instruction, one pending access
  int          m_pc, m_epc;
  bit          m_ie, m_z;
  int          m_reg [NREGS];
  bit          m_have_ir, m_mem, m_halt;
  logic [15:0] m_ir;
  bit          m_acc_we;
  int          m_acc_addr, m_acc_wdata, m_acc_rd;

  bit          rand_mode, irq_force, irq_armed;
  int          cfg_wait, wait_cnt, req_cnt;
  logic [7:0]  fixed_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = 0; m_epc = 0; m_ie = 0; m_z = 0;
    for (int i = 0; i < int'(NREGS); i++) m_reg[i] = 0;
    m_have_ir = 0; m_mem = 0; m_halt = 0; m_ir = 16'h0;
    m_acc_we = 0; m_acc_addr = 0; m_acc_wdata = 0; m_acc_rd = 0;
    wait_cnt = 0; irq_armed = 0;
  endtask

  task automatic take_irq();
    m_epc = m_pc;
    m_pc  = int'(IRQ_VEC) % AMOD;
    m_ie  = 0;
    irq_armed = 0;
  endtask

  task automatic model_exec(input logic [15:0] ir);
    int op, rd, rs, imm, a, b, res;
    op  = int'(ir[15:12]);
    rd  = int'(ir[11:8]) % int'(NREGS);
    rs  = int'(ir[7:4]) % int'(NREGS);
    imm = int'(ir[7:0]);
    a   = m_reg[rd];
    b   = m_reg[rs];
    res = 0;
    case (op)
      1:  m_reg[rd] = imm % DMOD;
      2:  res = (a + b) % DMOD;
      3:  res = (a - b + DMOD) % DMOD;
      4:  res = a & b;
      5:  res = a | b;
      6:  res = a ^ b;
`ifdef NOPCPU_MUL_EN
      7:  res = (a * b) % DMOD;
`else
      7:  res = (2 * b) % DMOD;
`endif
      8, 9: begin
        m_mem       = 1;
        m_acc_we    = (op == 9);
        m_acc_addr  = b % AMOD;
        m_acc_wdata = a;
        m_acc_rd    = rd;
        wait_cnt    = rand_mode ? int'($urandom_range(0, 3)) : cfg_wait;
      end
      10: m_pc = imm % AMOD;
      11: if (m_z) m_pc = imm % AMOD;
      12: begin m_pc = m_epc; m_ie = 1; end
      13: m_ie = 1;
      14: m_ie = 0;
      15: m_halt = 1;
      default: ;
    endcase
    if (op >= 2 && op <= 7) begin
      m_reg[rd] = res;
      m_z = (res == 0);
    end
  endtask

  task automatic model_step();
    if (m_mem) begin
      if (dmem_ack) begin
        if (!m_acc_we) m_reg[m_acc_rd] = int'(dmem_rdata);
        m_mem = 0;
      end
    end else if (m_halt) begin
      if (irq && m_ie) begin
        take_irq();
        m_halt = 0;
      end
    end else if (m_have_ir) begin
      m_have_ir = 0;
      model_exec(m_ir);
    end else if (irq && m_ie) begin
      take_irq();
    end else begin
      m_ir = rom[m_pc];
      m_pc = (m_pc + 1) % AMOD;
      m_have_ir = 1;
    end
  endtask

  task automatic drive_inputs();
    irq = irq_force || (irq_armed && m_pc == 16) || (rand_mode && $urandom_range(0, 7) == 0);
    if (m_mem) begin
      if (wait_cnt == 0) dmem_ack = 1'b1;
      else begin
        dmem_ack = 1'b0;
        wait_cnt--;
      end
    end else begin
      dmem_ack = rand_mode && ($urandom_range(0, 3) == 0);
    end
    dmem_rdata = rand_mode ? 8'($urandom) : fixed_rdata;
  endtask

  task automatic compare();
    chk("pc", 32'(imem_addr), 32'(m_pc));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("req", 32'(dmem_req), 32'(m_mem));
    if (m_mem) begin
      chk("we", 32'(dmem_we), 32'(m_acc_we));
      chk("addr", 32'(dmem_addr), 32'(m_acc_addr));
      chk("wdata", 32'(dmem_wdata), 32'(m_acc_wdata));
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      drive_inputs();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
    end
  endtask

  // Asserted between clock edges so the asynchronous path is what gets checked
  task automatic do_reset();
    reset = 1'b0; irq = 1'b0; dmem_ack = 1'b0;
    #1;
    model_reset();
    chk("rst_pc", 32'(imem_addr), 32'h0);
    chk("rst_req", 32'(dmem_req), 32'h0);
    chk("rst_we", 32'(dmem_we), 32'h0);
    chk("rst_addr", 32'(dmem_addr), 32'h0);
    chk("rst_wdata", 32'(dmem_wdata), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic random_rom();
    logic [3:0] op4;
    for (int i = 0; i < 256; i++) begin
      op4 = 4'($urandom_range(0, 15));
      if (op4 == 4'hF && $urandom_range(0, 3) != 0) op4 = 4'h0;
      rom[i] = {op4, 12'($urandom)};
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; irq = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    rand_mode = 0; irq_force = 0; irq_armed = 0; cfg_wait = 0; wait_cnt = 0;
    fixed_rdata = 8'hA5;

    // LDI/LDI/ADD, result observed through a store, then a not-taken JZ
    clear_rom();
    rom[0] = 16'h1105; rom[1] = 16'h1203; rom[2] = 16'h2120;
    rom[3] = 16'h9120; rom[4] = 16'hB030;
    do_reset();
    run_cycles(6);
    chk("t1_pc", 32'(imem_addr), 32'h3);
    run_cycles(2);
    chk("t1_req", 32'(dmem_req), 32'h1);
    chk("t1_addr", 32'(dmem_addr), 32'h3);
    chk("t1_wdata", 32'(dmem_wdata), 32'h8);
    run_cycles(1);
    chk("t1_req_drop", 32'(dmem_req), 32'h0);
    run_cycles(2);
    chk("t1_jz_not_taken", 32'(imem_addr), 32'h5);

    // SUB to zero then taken JZ
    clear_rom();
    rom[0] = 16'h1101; rom[1] = 16'h1201; rom[2] = 16'h3120; rom[3] = 16'hB020;
    do_reset();
    run_cycles(8);
    chk("t2_jz_taken", 32'(imem_addr), 32'h20);

    // Store with three wait cycles, then load 0xA5 and store it back
    clear_rom();
    rom[0] = 16'h115A; rom[1] = 16'h1233; rom[2] = 16'h9120;
    rom[3] = 16'h8320; rom[4] = 16'h9320;
    cfg_wait = 3;
    do_reset();
    run_cycles(6);
    chk("t3_req", 32'(dmem_req), 32'h1);
    chk("t3_we", 32'(dmem_we), 32'h1);
    chk("t3_addr", 32'(dmem_addr), 32'h33);
    chk("t3_wdata", 32'(dmem_wdata), 32'h5A);
    req_cnt = 1;
    repeat (3) begin
      run_cycles(1);
      if (dmem_req) req_cnt++;
    end
    run_cycles(1);
    chk("t3_req_after_ack", 32'(dmem_req), 32'h0);
    chk("t3_req_cycles", 32'(req_cnt), 32'd4);
    cfg_wait = 0;
    run_cycles(5);
    chk("t3_ld_st_we", 32'(dmem_we), 32'h1);
    chk("t3_ld_st_addr", 32'(dmem_addr), 32'h33);
    chk("t3_ld_st_wdata", 32'(dmem_wdata), 32'hA5);

    // EI, interrupt at PC 0x10, RETI, re-entry, no nesting inside the handler
    clear_rom();
    rom[0] = 16'hD000; rom[8'hF0] = 16'hC000;
    do_reset();
    irq_armed = 1;
    run_cycles(33);
    chk("t4_vector", 32'(imem_addr), 32'hF0);
    run_cycles(2);
    chk("t4_reti", 32'(imem_addr), 32'h10);
    irq_armed = 1;
    run_cycles(1);
    chk("t4_reenter", 32'(imem_addr), 32'hF0);
    irq_force = 1;
    run_cycles(1);
    chk("t4_no_nest", 32'(imem_addr), 32'hF1);
    irq_force = 0;

    // HALT freezes PC and ignores irq while IE=0
    clear_rom();
    rom[0] = 16'hF000;
    do_reset();
    run_cycles(2);
    chk("t5_halted", 32'(halted), 32'h1);
    chk("t5_pc", 32'(imem_addr), 32'h1);
    irq_force = 1;
    run_cycles(5);
    chk("t5_halted_irq", 32'(halted), 32'h1);
    chk("t5_pc_irq", 32'(imem_addr), 32'h1);
    irq_force = 0;

    // Reset in the middle of a pending load
    clear_rom();
    rom[0] = 16'h1207; rom[1] = 16'h8320;
    cfg_wait = 50;
    do_reset();
    run_cycles(4);
    chk("t5_ld_req", 32'(dmem_req), 32'h1);
    chk("t5_ld_addr", 32'(dmem_addr), 32'h7);
    do_reset();
    cfg_wait = 0;

    // Op 7: SHL in the default build, MUL when enabled
    clear_rom();
    rom[0] = 16'h1110; rom[1] = 16'h1210; rom[2] = 16'h7120;
    rom[3] = 16'hB040; rom[4] = 16'h9110;
    do_reset();
`ifdef NOPCPU_MUL_EN
    run_cycles(8);
    chk("t6_mul_zero_jz", 32'(imem_addr), 32'h40);
`else
    run_cycles(10);
    chk("t6_shl_addr", 32'(dmem_addr), 32'h20);
    chk("t6_shl_wdata", 32'(dmem_wdata), 32'h20);
`endif

    // Randomized programs, irqs, ack latencies and stray acks
    rand_mode = 1;
    for (int e = 0; e < 20; e++) begin
      random_rom();
      do_reset();
      run_cycles(300);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
